// File: rtl/menu_param.sv
// -----------------------------------------------------------------------------
// menu_param
//   Four-button menu controller. In BROWSE, up/dn walk through ENTRIES menu
//   entries. rt opens the selected value for digit-by-digit BCD editing. In
//   EDIT, up/dn change the cursor digit, and rt/lf move the cursor. rt past
//   digit 0 commits the value through a one-cycle sel_set strobe, which is
//   issued once conf_ready allows it. lf past the most significant digit
//   cancels the edit.
//
//   Optional feature: define MENU_AUTOREPEAT_EN to auto-repeat a held up/dn
//   button. The first repeat comes after HOLD_CYCLES ce-cycles, and further
//   repeats follow every REPEAT_CYCLES ce-cycles.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   ce           clock enable; nothing advances while low
//   btn_up/dn/lf/rt  active-low buttons, idle high
//   conf_ready   configuration store accepts a write
//   sel_index    selected entry
//   sel_value    stored value of sel_index (BCD)
//   new_value    edited value (BCD)
//   sel_set      one-cycle write strobe for new_value
//   blinking     one-hot cursor digit, bit 0 = least significant
//   editing      high in EDIT or COMMIT
//
// States
//   BROWSE | choosing an entry; sel_index moves, new_value holds
//   EDIT   | changing new_value digit under the cursor
//   COMMIT | waiting for conf_ready to issue sel_set
// -----------------------------------------------------------------------------
module menu_param #(
    parameter int ENTRIES       = 6,
    parameter int DIGITS        = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    localparam int IDX_W        = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  btn_up,
    input  logic                  btn_dn,
    input  logic                  btn_lf,
    input  logic                  btn_rt,
    input  logic                  conf_ready,
    output logic [IDX_W-1:0]      sel_index,
    input  logic [DIGITS*4-1:0]   sel_value,
    output logic [DIGITS*4-1:0]   new_value,
    output logic                  sel_set,
    output logic [DIGITS-1:0]     blinking,
    output logic                  editing
);

    localparam int CUR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);
    localparam logic [CUR_W-1:0] CUR_MSD  = CUR_W'(DIGITS - 1);

    if (ENTRIES < 2 || ENTRIES > 16 || DIGITS < 1 || DIGITS > 8 ||
        HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("menu_param: parameter out of range");
    end

    typedef enum logic [1:0] {BROWSE, EDIT, COMMIT} state_t;

    state_t                state, state_nx;
    logic [IDX_W-1:0]      idx_q, idx_nx;
    logic [DIGITS*4-1:0]   val_q, val_nx;
    logic [CUR_W-1:0]      cur_q, cur_nx;
    logic [3:0]            dig_cur, dig_new;

    // Button vector order: {rt, lf, dn, up}; bits are active-low.
    logic [3:0] btn_now, btn_prev, fall, ev;
    logic       rpt_up, rpt_dn;

    assign btn_now = {btn_rt, btn_lf, btn_dn, btn_up};
    assign fall    = btn_prev & ~btn_now;

    always_ff @(posedge clk) begin
        if (!rst_n)
            btn_prev <= 4'hF;
        else if (ce)
            btn_prev <= btn_now;
    end

`ifdef MENU_AUTOREPEAT_EN
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             up_alone, dn_alone, held, rpt_fire;

    assign up_alone = (btn_now == 4'b1110);
    assign dn_alone = (btn_now == 4'b1101);
    assign held     = up_alone | dn_alone;
    // Terminal count 1 fires on the same cycle as the reload, so the first
    // repeat lands exactly HOLD_CYCLES ce-cycles after the press.
    assign rpt_fire = held && (fall == 4'b0000) && (rpt_cnt == RPT_W'(1));
    assign rpt_up   = rpt_fire & up_alone;
    assign rpt_dn   = rpt_fire & dn_alone;

    always_ff @(posedge clk) begin
        if (!rst_n)
            rpt_cnt <= '0;
        else if (ce) begin
            if (!held)
                rpt_cnt <= '0;
            else if (|fall)
                rpt_cnt <= RPT_W'(HOLD_CYCLES);
            else if (rpt_fire)
                rpt_cnt <= RPT_W'(REPEAT_CYCLES);
            else if (rpt_cnt != '0)
                rpt_cnt <= rpt_cnt - RPT_W'(1);
        end
    end
`else
    assign rpt_up = 1'b0;
    assign rpt_dn = 1'b0;
`endif

    // Simultaneous presses cancel each other; only a lone press is an event.
    always_comb begin
        ev = 4'b0000;
        if ($onehot(fall))
            ev = fall;
        else
            ev = {2'b00, rpt_dn, rpt_up};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BROWSE;
            idx_q <= '0;
            val_q <= '0;
            cur_q <= '0;
        end else if (ce) begin
            state <= state_nx;
            idx_q <= idx_nx;
            val_q <= val_nx;
            cur_q <= cur_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        val_nx   = val_q;
        cur_nx   = cur_q;
        dig_cur  = 4'd0;
        dig_new  = 4'd0;

        for (int d = 0; d < DIGITS; d++)
            if (cur_q == CUR_W'(d))
                dig_cur = val_q[d*4 +: 4];

        // Non-BCD nibbles are folded back into 0..9 on the first edit.
        if (ev[0])
            dig_new = (dig_cur >= 4'd9) ? 4'd0 : dig_cur + 4'd1;
        else
            dig_new = (dig_cur == 4'd0 || dig_cur > 4'd9) ? 4'd9 : dig_cur - 4'd1;

        case (state)
            BROWSE: begin
                if (ev[0])
                    idx_nx = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
                else if (ev[1])
                    idx_nx = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                else if (ev[3]) begin
                    state_nx = EDIT;
                    val_nx   = sel_value;
                    cur_nx   = CUR_MSD;
                end
            end
            EDIT: begin
                if (ev[0] || ev[1]) begin
                    for (int d = 0; d < DIGITS; d++)
                        if (cur_q == CUR_W'(d))
                            val_nx[d*4 +: 4] = dig_new;
                end else if (ev[3]) begin
                    if (cur_q == '0)
                        state_nx = COMMIT;
                    else
                        cur_nx = cur_q - CUR_W'(1);
                end else if (ev[2]) begin
                    if (cur_q == CUR_MSD)
                        state_nx = BROWSE;
                    else
                        cur_nx = cur_q + CUR_W'(1);
                end
            end
            COMMIT: begin
                if (conf_ready)
                    state_nx = BROWSE;
            end
            default: state_nx = BROWSE;
        endcase
    end

    assign sel_index = idx_q;
    assign new_value = val_q;
    assign editing   = (state != BROWSE);
    assign blinking  = (state == EDIT) ? (DIGITS'(1) << cur_q) : '0;
    // rst_n gating keeps an aborted COMMIT from strobing in the reset cycle.
    assign sel_set   = rst_n & ce & conf_ready & (state == COMMIT);

endmodule

// File: tb/tb_menu_param.sv
module tb_menu_param;

    localparam int ENTRIES = 6;
    localparam int DIGITS  = 4;
    localparam int HOLD    = 8;
    localparam int REP     = 4;
    localparam int IDX_W   = 3;

    localparam bit [3:0] P_UP = 4'b0001;
    localparam bit [3:0] P_DN = 4'b0010;
    localparam bit [3:0] P_LF = 4'b0100;
    localparam bit [3:0] P_RT = 4'b1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic btn_up = 1'b1, btn_dn = 1'b1, btn_lf = 1'b1, btn_rt = 1'b1;
    logic conf_ready = 1'b0;
    logic [IDX_W-1:0]    sel_index;
    logic [DIGITS*4-1:0] sel_value, new_value;
    logic                sel_set, editing;
    logic [DIGITS-1:0]   blinking;

    logic [DIGITS*4-1:0] mem [8];
    assign sel_value = mem[sel_index];

    always #5 clk = ~clk;

    menu_param #(
        .ENTRIES(ENTRIES), .DIGITS(DIGITS),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .btn_up(btn_up), .btn_dn(btn_dn), .btn_lf(btn_lf), .btn_rt(btn_rt),
        .conf_ready(conf_ready), .sel_index(sel_index), .sel_value(sel_value),
        .new_value(new_value), .sel_set(sel_set), .blinking(blinking),
        .editing(editing)
    );

    int n_chk = 0;
    int n_fail = 0;
    int sel_pulses = 0;

    // Reference model: mode 0 browse, 1 edit, 2 commit; value kept as digit array.
    int       m_mode = 0, m_idx = 0, m_cur = 0, m_age = -1;
    int       m_dig [DIGITS];
    bit [3:0] m_held = 4'b0000;

    function automatic logic [DIGITS*4-1:0] m_val();
        logic [DIGITS*4-1:0] v = '0;
        for (int i = 0; i < DIGITS; i++)
            v = v | ((DIGITS*4)'(m_dig[i]) << (4*i));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit [3:0] p, input bit c, input bit cr, input bit r);
        bit [3:0]            fall;
        int                  ev;
        logic [DIGITS*4-1:0] w;
        if (!r) begin
            m_mode = 0; m_idx = 0; m_cur = 0; m_age = -1; m_held = 4'b0000;
            for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
            return;
        end
        if (!c) return;
        fall = p & ~m_held;
        ev = -1;
        if ($countones(fall) == 1)
            for (int i = 0; i < 4; i++) if (fall[i]) ev = i;
`ifdef MENU_AUTOREPEAT_EN
        if (!(p == P_UP || p == P_DN))
            m_age = -1;
        else if (fall != 4'b0000)
            m_age = 0;
        else if (m_age >= 0) begin
            m_age++;
            if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))
                ev = (p == P_UP) ? 0 : 1;
        end
`endif
        m_held = p;
        case (m_mode)
            0: begin
                if (ev == 0) m_idx = (m_idx + ENTRIES - 1) % ENTRIES;
                else if (ev == 1) m_idx = (m_idx + 1) % ENTRIES;
                else if (ev == 3) begin
                    m_mode = 1;
                    m_cur = DIGITS - 1;
                    w = mem[m_idx];
                    for (int i = 0; i < DIGITS; i++) m_dig[i] = int'(w[4*i +: 4]);
                end
            end
            1: begin
                if (ev == 0) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
                else if (ev == 1) m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
                else if (ev == 3) begin
                    if (m_cur == 0) m_mode = 2; else m_cur--;
                end else if (ev == 2) begin
                    if (m_cur == DIGITS - 1) m_mode = 0; else m_cur++;
                end
            end
            default: if (cr) m_mode = 0;
        endcase
    endtask

    task automatic cyc(input bit [3:0] p, input bit c, input bit cr, input bit r);
        @(negedge clk);
        {btn_rt, btn_lf, btn_dn, btn_up} = ~p;
        ce = c; conf_ready = cr; rst_n = r;
        #1;
        chk("sel_set", 32'(sel_set), 32'(m_mode == 2 && c && cr && r));
        if (sel_set === 1'b1) begin
            sel_pulses++;
            mem[sel_index] = new_value;
        end
        @(posedge clk);
        model_edge(p, c, cr, r);
        #1;
        chk("sel_index", 32'(sel_index), 32'(m_idx));
        chk("new_value", 32'(new_value), 32'(m_val()));
        chk("blinking", 32'(blinking), (m_mode == 1) ? (32'd1 << m_cur) : 32'd0);
        chk("editing", 32'(editing), 32'(m_mode != 0));
    endtask

    task automatic press(input bit [3:0] p, input bit cr);
        cyc(p, 1'b1, cr, 1'b1);
        cyc(4'b0000, 1'b1, cr, 1'b1);
    endtask

    initial begin
        int exp_walk [7] = '{1, 2, 3, 4, 5, 0, 1};
        logic [DIGITS*4-1:0] rv;
        bit [3:0] rp;

        for (int i = 0; i < 8; i++) mem[i] = '0;

        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rst_index", 32'(sel_index), 32'd0);
        chk("rst_editing", 32'(editing), 32'd0);
        chk("rst_blink", 32'(blinking), 32'd0);

        for (int i = 0; i < 7; i++) begin
            press(P_DN, 1'b1);
            chk("dn_walk", 32'(sel_index), 32'(exp_walk[i]));
        end

        mem[1] = 16'h1234;
        press(P_RT, 1'b1);
        chk("edit_load", 32'(new_value), 32'h1234);
        for (int i = 0; i < 3; i++) press(P_UP, 1'b1);
        chk("up3", 32'(new_value), 32'h4234);
        chk("blink_msd", 32'(blinking), 32'b1000);
        for (int i = 0; i < 5; i++) press(P_DN, 1'b1);
        chk("dn5_wrap", 32'(new_value), 32'h9234);

        sel_pulses = 0;
        for (int i = 0; i < 4; i++) press(P_RT, 1'b0);
        for (int i = 0; i < 5; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        chk("commit_wait", 32'(editing), 32'd1);
        chk("commit_nopulse", 32'(sel_pulses), 32'd0);
        cyc(4'b0000, 1'b1, 1'b1, 1'b1);
        chk("commit_pulses", 32'(sel_pulses), 32'd1);
        chk("commit_editing", 32'(editing), 32'd0);
        chk("commit_written", 32'(mem[1]), 32'h9234);

        sel_pulses = 0;
        press(P_RT, 1'b1);
        chk("cancel_blink_in", 32'(blinking), 32'b1000);
        press(P_LF, 1'b1);
        chk("cancel_blink", 32'(blinking), 32'd0);
        chk("cancel_editing", 32'(editing), 32'd0);
        chk("cancel_nopulse", 32'(sel_pulses), 32'd0);

        for (int i = 0; i < 4; i++) press(P_RT, 1'b0);
        chk("pre_rst_commit", 32'(editing), 32'd1);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("rst_abort_index", 32'(sel_index), 32'd0);
        chk("rst_abort_edit", 32'(editing), 32'd0);
        chk("rst_abort_nopulse", 32'(sel_pulses), 32'd0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        press(P_UP | P_DN, 1'b1);
        chk("dual_press", 32'(sel_index), 32'd0);

        for (int i = 0; i < 3; i++) cyc(P_DN, 1'b0, 1'b1, 1'b1);
        chk("ce_hold", 32'(sel_index), 32'd0);
        cyc(P_DN, 1'b1, 1'b1, 1'b1);
        chk("ce_resume", 32'(sel_index), 32'd1);
        cyc(4'b0000, 1'b1, 1'b1, 1'b1);
        press(P_UP, 1'b1);
        chk("up_to_zero", 32'(sel_index), 32'd0);
        press(P_UP, 1'b1);
        chk("up_wrap", 32'(sel_index), 32'(ENTRIES - 1));
        press(P_DN, 1'b1);

        for (int i = 0; i < 21; i++) cyc(P_DN, 1'b1, 1'b1, 1'b1);
        cyc(4'b0000, 1'b1, 1'b1, 1'b1);
`ifdef MENU_AUTOREPEAT_EN
        chk("hold_repeat", 32'(sel_index), 32'd5);
`else
        chk("hold_single", 32'(sel_index), 32'd1);
`endif

        for (int e = 0; e < 8; e++) begin
            rv = '0;
            for (int i = 0; i < DIGITS; i++) rv[4*i +: 4] = 4'($urandom_range(0, 9));
            mem[e] = rv;
        end
        for (int n = 0; n < 800; n++) begin
            rp = 4'b0000;
            if ($urandom_range(0, 1) == 0)
                for (int i = 0; i < 4; i++) rp[i] = ($urandom_range(0, 5) == 0);
            cyc(rp, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 199) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
